// File: rtl/core_pkg.sv
// Shared MDU definitions: op encodings, FSM state type and operand-sign helpers.
package core_pkg;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;

  function automatic logic rs1_signed(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic rs2_signed(input logic [MDU_OP_WIDTH-1:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes: one quotient bit per step_i pulse.
// quo_o/rem_o present the post-step values so the caller can capture the final step.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] div_q, rem_q, quo_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN:0]   trial;

  // trial[XLEN] is the borrow: set means the divisor does not fit, so restore
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
    if (trial[XLEN]) begin
      rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = trial[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (load_i) begin
      div_q <= divisor_i;
      rem_q <= '0;
      quo_q <= dividend_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quo_o = quo_d;
  assign rem_o = rem_d;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiplier, optional restoring divider.
// Divider compiled in only when MDU_DIV_EN is defined; otherwise op[2]=1 reports illegal.
module mdu_iter
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [MDU_OP_WIDTH-1:0] in_op_i,
  input  logic [XLEN-1:0]         in_rs1_i,
  input  logic [XLEN-1:0]         in_rs2_i,
  input  logic [TAG_W-1:0]        in_tag_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         out_result_o,
  output logic [TAG_W-1:0]        out_tag_o,
  output logic                    out_illegal_o,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mdu_state_t              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [MDU_OP_WIDTH-1:0] op_q;
  logic [XLEN-1:0]         mag1_q;
  logic [2*XLEN-1:0]       prod_q;
  logic                    neg_q;
  logic                    out_valid_q, out_illegal_q;
  logic [XLEN-1:0]         out_result_q;
  logic [TAG_W-1:0]        out_tag_q;

  logic                    accept, s1, s2, neg_in;
  logic [XLEN-1:0]         mag1, mag2;
  logic [XLEN:0]           add_sum;
  logic [2*XLEN-1:0]       prod_d, prod_fin;
  logic [XLEN-1:0]         mul_res_d;

  assign in_ready_o = (state_q == S_IDLE) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q != S_IDLE);

  // Signs only count for the signed operand positions of each op
  assign s1     = rs1_signed(in_op_i) && in_rs1_i[XLEN-1];
  assign s2     = rs2_signed(in_op_i) && in_rs2_i[XLEN-1];
  assign mag1   = s1 ? -in_rs1_i : in_rs1_i;
  assign mag2   = s2 ? -in_rs2_i : in_rs2_i;
  assign neg_in = (in_op_i[2] && in_op_i[1]) ? s1 : (s1 ^ s2);

  // Multiplier sits in the low half and shifts out as the product shifts in
  assign add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag1_q} : '0);
  assign prod_d    = {add_sum, prod_q[XLEN-1:1]};
  assign prod_fin  = neg_q ? -prod_d : prod_d;
  assign mul_res_d = (op_q == MDU_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] rs1_q, quo_mag, rem_mag, div_res_d, spec_res_d;
  logic            div0_q, ovf_q, div0_in, ovf_in;

  assign div0_in = (in_rs2_i == '0);
  assign ovf_in  = !in_op_i[0] && (in_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2_i == '1);

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (accept && in_op_i[2]),
    .step_i     (state_q == S_DIV),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .quo_o      (quo_mag),
    .rem_o      (rem_mag)
  );

  assign div_res_d  = op_q[1] ? (neg_q ? -rem_mag : rem_mag) : (neg_q ? -quo_mag : quo_mag);
  assign spec_res_d = div0_q ? (op_q[1] ? rs1_q : '1) : (op_q[1] ? '0 : rs1_q);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      mag1_q        <= '0;
      prod_q        <= '0;
      neg_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
`ifdef MDU_DIV_EN
      rs1_q         <= '0;
      div0_q        <= 1'b0;
      ovf_q         <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid_i) begin
          op_q      <= in_op_i;
          mag1_q    <= mag1;
          prod_q    <= {{XLEN{1'b0}}, mag2};
          neg_q     <= neg_in;
          out_tag_q <= in_tag_i;
          cnt_q     <= '0;
          state_q   <= in_op_i[2] ? S_DIV : S_MUL;
`ifdef MDU_DIV_EN
          rs1_q     <= in_rs1_i;
          div0_q    <= div0_in;
          ovf_q     <= ovf_in;
`endif
        end
        S_MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_q         <= '0;
            state_q       <= S_DONE;
            out_valid_q   <= 1'b1;
            out_result_q  <= mul_res_d;
            out_illegal_q <= 1'b0;
          end
        end
        S_DIV: begin
`ifdef MDU_DIV_EN
          // Corner cases resolve on the first DIV cycle without iterating
          cnt_q <= cnt_q + CNT_W'(1);
          if (div0_q || ovf_q) begin
            cnt_q         <= '0;
            state_q       <= S_DONE;
            out_valid_q   <= 1'b1;
            out_result_q  <= spec_res_d;
            out_illegal_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q         <= '0;
            state_q       <= S_DONE;
            out_valid_q   <= 1'b1;
            out_result_q  <= div_res_d;
            out_illegal_q <= 1'b0;
          end
`else
          state_q       <= S_DONE;
          out_valid_q   <= 1'b1;
          out_result_q  <= '0;
          out_illegal_q <= 1'b1;
`endif
        end
        S_DONE: if (out_ready_i) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_result_o  = out_result_q;
  assign out_tag_o     = out_tag_q;
  assign out_illegal_o = out_illegal_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=32): arithmetic reference model plus per-cycle compare.
// Divide vectors run only when MDU_DIV_EN is defined; otherwise the illegal path is exercised.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_illegal, busy;
  logic [2:0]  in_op;
  logic [31:0] in_rs1, in_rs2, out_result;
  logic [4:0]  in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0, chk_data = 1'b0;
  logic        exp_ready, exp_busy, exp_valid, exp_ill;
  logic [31:0] exp_result;
  logic [4:0]  exp_tag;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_rs1_i     (in_rs1),
    .in_rs2_i     (in_rs2),
    .in_tag_i     (in_tag),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_tag_o    (out_tag),
    .out_illegal_o(out_illegal),
    .busy_o       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {illegal, result} from plain 64-bit arithmetic
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic        ill;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    ill = 1'b0;
    r = '0;
    p = '0;
    q = 0;
    if (!op[2]) begin
      case (op[1:0])
        2'd0: begin p = sa * sb;           r = p[31:0];  end
        2'd1: begin p = sa * sb;           r = p[63:32]; end
        2'd2: begin p = sa * longint'(ub); r = p[63:32]; end
        default: begin p = ua * ub;        r = p[63:32]; end
      endcase
    end else begin
`ifdef MDU_DIV_EN
      case (op[1:0])
        2'd0: if (b == 0) r = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
              else begin q = sa / sb; r = q[31:0]; end
        2'd1: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        2'd2: if (b == 0) r = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
              else begin q = sa % sb; r = q[31:0]; end
        default: r = (b == 0) ? a : a % b;
      endcase
`else
      ill = 1'b1;
`endif
    end
    return {ill, r};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("out_valid", out_valid, exp_valid);
      if (chk_data) begin
        chk("out_result", out_result, exp_result);
        chk("out_tag", out_tag, exp_tag);
        chk("out_illegal", out_illegal, exp_ill);
      end
    end
  end

  task automatic set_idle();
    exp_ready = 1'b1; exp_busy = 1'b0; exp_valid = 1'b0; chk_data = 1'b0;
  endtask

  // One transaction: accept, run, optionally stall the consumer or flush at cycle flush_k
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input int flush_k,
                        input logic [31:0] lit, input logic lit_ill);
    logic [32:0] m;
    int lat;
    bit done;
    m = ref_op(op, a, b);
    lat = 33;
    if (op[2]) begin
`ifdef MDU_DIV_EN
      if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 2;
`else
      lat = 2;
`endif
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    flush = 1'b0; out_ready = 1'b0;
    set_idle();
    done = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(posedge clk); #1;
      in_valid = 1'(($urandom_range(0, 1)));
      in_rs1 = $urandom; in_rs2 = $urandom; in_tag = 5'($urandom);
      exp_busy = 1'b1; exp_ready = 1'b0; exp_valid = (k >= lat);
      if (k >= lat) begin
        exp_result = m[31:0]; exp_tag = tag; exp_ill = m[32]; chk_data = 1'b1;
      end
      out_ready = (k >= lat + hold);
      flush = (k == flush_k);
      if (k == lat) begin
        @(negedge clk);
        chk("lit_result", out_result, lit);
        chk("lit_illegal", out_illegal, lit_ill);
      end
      if (flush || out_ready) done = 1'b1;
    end
    if (!done) chk("op_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;

    chk("pin_mulh",   ref_op(3'd1, 32'h8000_0000, 32'h8000_0000), {1'b0, 32'h4000_0000});
    chk("pin_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 32'hFFFF_FFFF});
    chk("pin_mulhu",  ref_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002), {1'b0, 32'h0000_0001});
`ifdef MDU_DIV_EN
    chk("pin_div",    ref_op(3'd4, 32'hFFFF_FFF9, 32'h2), {1'b0, 32'hFFFF_FFFD});
    chk("pin_rem",    ref_op(3'd6, 32'hFFFF_FFF9, 32'h2), {1'b0, 32'hFFFF_FFFF});
`else
    chk("pin_div_ill", ref_op(3'd4, 32'd10, 32'd3), {1'b1, 32'h0});
`endif

    // Reset state
    @(posedge clk); #1;
    exp_ready = 1'b1; exp_busy = 1'b0; exp_valid = 1'b0;
    exp_result = '0; exp_tag = '0; exp_ill = 1'b0; chk_data = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_idle();

    // Multiply vectors
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'h01, 0, 0, 32'h4000_0000, 1'b0);
    run_op(3'd0, 32'h0000_0003, 32'h0000_0004, 5'h1A, 5, 0, 32'h0000_000C, 1'b0);
    run_op(3'd0, 32'hFFFF_FFF9, 32'h0000_0003, 5'h02, 1, 0, 32'hFFFF_FFEB, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'h04, 2, 0, 32'h3FFF_FFFF, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, 0, 0, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 5'h06, 0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'h0000_0000, 32'hFFFF_FFFF, 5'h07, 0, 0, 32'h0000_0000, 1'b0);

    // Flush mid-operation, then a clean MULHU
`ifdef MDU_DIV_EN
    run_op(3'd5, 32'd100, 32'd7, 5'h08, 0, 10, 32'd14, 1'b0);
`else
    run_op(3'd0, 32'd100, 32'd7, 5'h08, 0, 10, 32'd700, 1'b0);
`endif
    run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'h09, 0, 0, 32'h0000_0001, 1'b0);

    // Flush colliding with the out_ready handshake in DONE
    run_op(3'd0, 32'd5, 32'd5, 5'h0A, 0, 33, 32'd25, 1'b0);

    // Flush while idle blocks a simultaneous request
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'd2; in_rs2 = 32'd2;
    exp_ready = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; chk_data = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    set_idle();
    @(posedge clk); #1;

`ifdef MDU_DIV_EN
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'h0B, 0, 0, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'h0C, 0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 5'h0D, 0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0E, 0, 0, 32'h0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0F, 1, 0, 32'h8000_0000, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'h10, 0, 0, 32'd2, 1'b0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 5'h11, 0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'h12, 0, 0, 32'd1, 1'b0);
    run_op(3'd4, 32'd7, 32'd0, 5'h13, 0, 0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 5'h14, 3, 0, 32'd5, 1'b0);
`else
    run_op(3'd4, 32'd10, 32'd3, 5'h0B, 0, 0, 32'h0, 1'b1);
    run_op(3'd7, 32'd10, 32'd3, 5'h0C, 2, 0, 32'h0, 1'b1);
`endif
    run_op(3'd0, 32'd6, 32'd7, 5'h15, 0, 0, 32'd42, 1'b0);

    // Reset mid-operation discards work
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'h03;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_busy = 1'b1; exp_ready = 1'b0; exp_valid = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b1; exp_busy = 1'b0; exp_valid = 1'b0;
    exp_result = '0; exp_tag = '0; exp_ill = 1'b0; chk_data = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_idle();
    run_op(3'd0, 32'd3, 32'd4, 5'h16, 0, 0, 32'h0000_000C, 1'b0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
